// File: rtl/otp_auth_ctrl.sv
// Two-digit one-time-password check: captures an OTP from the LFSR, collects two
// user digits, compares them, and enforces retry limits, an entry timeout and a lockout.
module otp_auth_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCK_CYC    = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       otp_latch,
  input  logic       user_latch,
  input  logic [3:0] user_in,
  input  logic [7:0] otp_code,
  output logic [7:0] otp_digits,
  output logic [7:0] entry_digits,
  output logic [1:0] entry_cnt,
  output logic       pass,
  output logic       fail,
  output logic       expired,
  output logic       locked,
  output logic [1:0] tries_left,
  output logic       lfsr_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_D0, S_WAIT_D1, S_CHECK, S_PASS, S_LOCK
  } state_e;

  localparam logic [1:0]  TRIES_INIT   = 2'(MAX_TRIES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  otp_digits_q, otp_digits_d;
  logic [7:0]  entry_digits_q, entry_digits_d;
  logic [1:0]  entry_cnt_q, entry_cnt_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        expired_q, expired_d;
  logic        locked_q, locked_d;
  logic [1:0]  tries_left_q, tries_left_d;
  logic        lfsr_hold_q, lfsr_hold_d;
  logic [15:0] timer_q, timer_d;

  function automatic logic [15:0] timer_inc(input logic [15:0] t);
    return (t == 16'hFFFF) ? t : t + 16'd1;
  endfunction

  always_comb begin
    state_d        = state_q;
    otp_digits_d   = otp_digits_q;
    entry_digits_d = entry_digits_q;
    entry_cnt_d    = entry_cnt_q;
    pass_d         = pass_q;
    fail_d         = 1'b0;
    expired_d      = 1'b0;
    locked_d       = locked_q;
    tries_left_d   = tries_left_q;
    timer_d        = timer_q;

    case (state_q)
      S_IDLE: begin
        if (otp_latch) begin
          otp_digits_d = otp_code;
          entry_cnt_d  = 2'd0;
          timer_d      = 16'd0;
          state_d      = S_WAIT_D0;
        end
      end
      S_WAIT_D0, S_WAIT_D1: begin
        // A new OTP request outranks a digit strobe and keeps the remaining tries.
        if (otp_latch) begin
          otp_digits_d = otp_code;
          entry_cnt_d  = 2'd0;
          timer_d      = 16'd0;
          state_d      = S_WAIT_D0;
        end else if (user_latch) begin
          timer_d = 16'd0;
          if (state_q == S_WAIT_D0) begin
            entry_digits_d[7:4] = user_in;
            entry_cnt_d         = 2'd1;
            state_d             = S_WAIT_D1;
          end else begin
            entry_digits_d[3:0] = user_in;
            entry_cnt_d         = 2'd2;
            state_d             = S_CHECK;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          expired_d    = 1'b1;
          otp_digits_d = 8'h00;
          entry_cnt_d  = 2'd0;
          timer_d      = 16'd0;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_inc(timer_q);
        end
      end
      S_CHECK: begin
        timer_d = 16'd0;
        if (entry_digits_q == otp_digits_q) begin
          pass_d       = 1'b1;
          tries_left_d = TRIES_INIT;
          state_d      = S_PASS;
        end else if (tries_left_q > 2'd1) begin
          fail_d         = 1'b1;
          tries_left_d   = tries_left_q - 2'd1;
          entry_cnt_d    = 2'd0;
          entry_digits_d = 8'h00;
          state_d        = S_WAIT_D0;
        end else begin
          fail_d       = 1'b1;
          tries_left_d = 2'd0;
          locked_d     = 1'b1;
          state_d      = S_LOCK;
        end
      end
      S_PASS: begin
        if (otp_latch) begin
          pass_d       = 1'b0;
          otp_digits_d = otp_code;
          entry_cnt_d  = 2'd0;
          timer_d      = 16'd0;
          state_d      = S_WAIT_D0;
        end
      end
      S_LOCK: begin
        if (timer_q == LOCK_LAST) begin
          locked_d     = 1'b0;
          tries_left_d = TRIES_INIT;
          timer_d      = 16'd0;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_inc(timer_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    lfsr_hold_d = (state_d == S_WAIT_D0) || (state_d == S_WAIT_D1) ||
                  (state_d == S_CHECK)   || (state_d == S_PASS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      otp_digits_q   <= 8'h00;
      entry_digits_q <= 8'h00;
      entry_cnt_q    <= 2'd0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      expired_q      <= 1'b0;
      locked_q       <= 1'b0;
      tries_left_q   <= TRIES_INIT;
      lfsr_hold_q    <= 1'b0;
      timer_q        <= 16'd0;
    end else begin
      state_q        <= state_d;
      otp_digits_q   <= otp_digits_d;
      entry_digits_q <= entry_digits_d;
      entry_cnt_q    <= entry_cnt_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      expired_q      <= expired_d;
      locked_q       <= locked_d;
      tries_left_q   <= tries_left_d;
      lfsr_hold_q    <= lfsr_hold_d;
      timer_q        <= timer_d;
    end
  end

  assign otp_digits   = otp_digits_q;
  assign entry_digits = entry_digits_q;
  assign entry_cnt    = entry_cnt_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign expired      = expired_q;
  assign locked       = locked_q;
  assign tries_left   = tries_left_q;
  assign lfsr_hold    = lfsr_hold_q;

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Bench for otp_auth_ctrl: fixed vector table, hand sequences for timeout/lockout/reset,
// and random traffic checked every cycle against a session-level reference model.
module tb_otp_auth_ctrl;

  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 1000;
  localparam int LOCK_CYC    = 5000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       otp_latch = 1'b0;
  logic       user_latch = 1'b0;
  logic [3:0] user_in = 4'h0;
  logic [7:0] otp_code = 8'h00;
  logic [7:0] otp_digits, entry_digits;
  logic [1:0] entry_cnt, tries_left;
  logic       pass, fail, expired, locked, lfsr_hold;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  otp_auth_ctrl #(
    .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .otp_latch(otp_latch), .user_latch(user_latch),
    .user_in(user_in), .otp_code(otp_code), .otp_digits(otp_digits),
    .entry_digits(entry_digits), .entry_cnt(entry_cnt), .pass(pass), .fail(fail),
    .expired(expired), .locked(locked), .tries_left(tries_left), .lfsr_hold(lfsr_hold)
  );

  // Reference model: a session holding an OTP, a list of entered digits,
  // an idle counter, a pending comparison and a lockout countdown.
  bit         m_hold, m_passed, m_check, m_fail, m_exp;
  int         m_lock_left, m_idle, m_tries;
  logic [7:0] m_otp, m_entry;
  logic [3:0] m_dq[$];

  task automatic model_reset();
    m_hold = 0; m_passed = 0; m_check = 0; m_fail = 0; m_exp = 0;
    m_lock_left = 0; m_idle = 0; m_tries = MAX_TRIES;
    m_otp = 8'h00; m_entry = 8'h00; m_dq.delete();
  endtask

  task automatic model_capture(input logic [7:0] code);
    m_otp = code; m_dq.delete(); m_idle = 0; m_hold = 1;
  endtask

  task automatic model_step(input bit ol, input bit ul, input logic [3:0] ui,
                            input logic [7:0] code);
    m_fail = 0; m_exp = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_tries = MAX_TRIES;
    end else if (m_check) begin
      m_check = 0;
      if ({m_dq[0], m_dq[1]} == m_otp) begin
        m_passed = 1; m_tries = MAX_TRIES;
      end else begin
        m_fail = 1; m_tries--;
        if (m_tries == 0) begin
          m_lock_left = LOCK_CYC; m_hold = 0;
        end else begin
          m_dq.delete(); m_entry = 8'h00; m_idle = 0;
        end
      end
    end else if (m_passed) begin
      if (ol) begin m_passed = 0; model_capture(code); end
    end else if (m_hold) begin
      if (ol) model_capture(code);
      else if (ul) begin
        m_dq.push_back(ui); m_idle = 0;
        if (m_dq.size() == 1) m_entry[7:4] = ui;
        else begin m_entry[3:0] = ui; m_check = 1; end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_exp = 1; m_otp = 8'h00; m_dq.delete(); m_hold = 0;
        end
      end
    end else if (ol) model_capture(code);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [25:0] a, e;
    a = {otp_digits, entry_digits, entry_cnt, pass, fail, expired, locked, tries_left, lfsr_hold};
    e = {m_otp, m_entry, 2'(m_dq.size()), m_passed, m_fail, m_exp, (m_lock_left > 0),
         2'(m_tries), m_hold};
    check("model", 32'(a), 32'(e));
  endtask

  task automatic tick(input bit ol, input bit ul, input logic [3:0] ui, input logic [7:0] code);
    otp_latch = ol; user_latch = ul; user_in = ui; otp_code = code;
    @(posedge clk); #1;
    model_step(ol, ul, ui, code);
    compare_model();
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    #2;
    check(name, {otp_digits, entry_digits, entry_cnt, pass, fail, expired, locked,
                 tries_left, lfsr_hold},
          {8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0});
    otp_latch = 0; user_latch = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wrong_attempt();
    tick(0, 1, 4'h0, 8'h00);
    tick(0, 1, 4'h0, 8'h00);
    tick(0, 0, 4'h0, 8'h00);
  endtask

  typedef struct {
    bit ol; bit ul; logic [3:0] ui; logic [7:0] code;
    logic [7:0] e_otp; logic [7:0] e_entry; logic [1:0] e_cnt;
    bit e_pass; bit e_fail; logic [1:0] e_tries; bit e_hold;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    logic [3:0] d;

    tbl[0]  = '{1, 0, 4'h0, 8'h5A, 8'h5A, 8'h00, 2'd0, 0, 0, 2'd3, 1};
    tbl[1]  = '{0, 1, 4'h5, 8'h00, 8'h5A, 8'h50, 2'd1, 0, 0, 2'd3, 1};
    tbl[2]  = '{0, 1, 4'hA, 8'h00, 8'h5A, 8'h5A, 2'd2, 0, 0, 2'd3, 1};
    tbl[3]  = '{0, 0, 4'h0, 8'h00, 8'h5A, 8'h5A, 2'd2, 1, 0, 2'd3, 1};
    tbl[4]  = '{0, 1, 4'h3, 8'h00, 8'h5A, 8'h5A, 2'd2, 1, 0, 2'd3, 1};
    tbl[5]  = '{1, 0, 4'h0, 8'h5A, 8'h5A, 8'h5A, 2'd0, 0, 0, 2'd3, 1};
    tbl[6]  = '{0, 1, 4'h5, 8'h00, 8'h5A, 8'h5A, 2'd1, 0, 0, 2'd3, 1};
    tbl[7]  = '{0, 1, 4'hB, 8'h00, 8'h5A, 8'h5B, 2'd2, 0, 0, 2'd3, 1};
    tbl[8]  = '{0, 0, 4'h0, 8'h00, 8'h5A, 8'h00, 2'd0, 0, 1, 2'd2, 1};
    tbl[9]  = '{0, 0, 4'h0, 8'h00, 8'h5A, 8'h00, 2'd0, 0, 0, 2'd2, 1};
    tbl[10] = '{0, 1, 4'h5, 8'h00, 8'h5A, 8'h50, 2'd1, 0, 0, 2'd2, 1};
    tbl[11] = '{1, 1, 4'h5, 8'hC3, 8'hC3, 8'h50, 2'd0, 0, 0, 2'd2, 1};
    tbl[12] = '{0, 1, 4'hC, 8'h00, 8'hC3, 8'hC0, 2'd1, 0, 0, 2'd2, 1};
    tbl[13] = '{0, 1, 4'h3, 8'h00, 8'hC3, 8'hC3, 2'd2, 0, 0, 2'd2, 1};
    tbl[14] = '{0, 0, 4'h0, 8'h00, 8'hC3, 8'hC3, 2'd2, 1, 0, 2'd3, 1};

    #1;
    do_reset("reset_init");

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].ol, tbl[i].ul, tbl[i].ui, tbl[i].code);
      check($sformatf("table_row%0d", i),
            {otp_digits, entry_digits, entry_cnt, pass, fail, tries_left, lfsr_hold},
            {tbl[i].e_otp, tbl[i].e_entry, tbl[i].e_cnt, tbl[i].e_pass, tbl[i].e_fail,
             tbl[i].e_tries, tbl[i].e_hold});
    end

    // Three wrong entries lock the controller; latches are ignored until it expires.
    tick(1, 0, 4'h0, 8'h12);
    for (int k = 0; k < 3; k++) wrong_attempt();
    check("lock_entry", {locked, tries_left, fail, lfsr_hold}, {1'b1, 2'd0, 1'b1, 1'b0});
    bad = 0;
    for (int k = 0; k < LOCK_CYC - 1; k++) begin
      tick($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 8'($urandom));
      if (!locked || lfsr_hold || pass || fail || otp_digits != 8'h12) bad = 1;
    end
    check("lock_held", 32'(bad), 32'd0);
    tick(0, 0, 4'h0, 8'h00);
    check("lock_release", {locked, tries_left, lfsr_hold}, {1'b0, 2'd3, 1'b0});

    // Entry timeout after one digit.
    tick(1, 0, 4'h0, 8'h77);
    tick(0, 1, 4'h7, 8'h00);
    bad = 0;
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) begin
      tick(0, 0, 4'h0, 8'h00);
      if (expired) bad = 1;
    end
    check("no_early_expire", 32'(bad), 32'd0);
    tick(0, 0, 4'h0, 8'h00);
    check("expire", {expired, fail, otp_digits, entry_cnt, lfsr_hold, tries_left},
          {1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'd3});
    tick(0, 0, 4'h0, 8'h00);
    check("expire_pulse_end", 32'(expired), 32'd0);

    // Asynchronous reset in the middle of a lockout.
    tick(1, 0, 4'h0, 8'h34);
    for (int k = 0; k < 3; k++) wrong_attempt();
    check("lock_again", {locked, tries_left}, {1'b1, 2'd0});
    for (int k = 0; k < 10; k++) tick(0, 0, 4'h0, 8'h00);
    #3;
    do_reset("reset_in_lock");

    // Random traffic, mostly correct digits so passes and failures both occur.
    for (int k = 0; k < 4000; k++) begin
      d = 4'($urandom);
      if (m_hold && $urandom_range(0, 99) < 80)
        d = (m_dq.size() == 0) ? m_otp[7:4] : m_otp[3:0];
      tick($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 40, d, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
